// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: FSM state encoding,
// the BCD count layout and the active-low 7-segment lookup table.
package stopwatch_pkg;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_e;

    // Live count, most significant digit first so the packed value maps
    // directly onto the 16-bit debug bcd output.
    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
    } bcd_t;

    // Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Indexed by digit value; entries 10..15 are blank.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        SEG_ZERO     // 0
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit BCD to active-low 7-segment decoder. Values 10..15
// produce a blank digit.
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[bcd_i];

endmodule

// File: rtl/stopwatch_mmss.sv
// MM:SS BCD stopwatch driven by an asynchronous slow clock. The slow clock
// is synchronised and edge-detected into a one-cycle tick, counted while
// RUNNING, and shown on four registered active-low 7-segment digits.
// Optional feature: define STOPWATCH_LAP_EN to add the lap port and the
// display-hold register.
module stopwatch_mmss
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,  // synchroniser depth, must be >= 2
    parameter int EDGE_MODE   = 0   // 0: tick on rise, 1: tick on rise and fall
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        slow_clk,
    input  logic        start_stop,
    input  logic        clear,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap,
`endif
    output logic [15:0] bcd,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic        running,
    output logic        rollover
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   tick_q;
    logic                   tick_d;
    state_e                 state_q;
    logic                   running_q;
    bcd_t                   count_q;
    bcd_t                   count_d;
    logic                   roll_q;
    logic                   roll_d;
    logic                   count_en;
    logic                   hex_upd;
    logic [3:0][6:0]        seg_w;
    logic [3:0][6:0]        hex_q;

    // The tick is registered so a slow_clk edge reaches tick_q
    // SYNC_STAGES+1 cycles later.
    assign tick_d = (EDGE_MODE != 0) ? (sync_q[SYNC_STAGES-1] ^ edge_q)
                                     : (sync_q[SYNC_STAGES-1] & ~edge_q);

    // Synchroniser chain, previous-level register and registered tick.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // pre-edge value of its neighbour, so the chain truly shifts.
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            edge_q <= sync_q[SYNC_STAGES-1];
            tick_q <= tick_d;
        end
    end

    // Start/stop FSM with a registered running flag.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STOPPED;
            running_q <= 1'b0;
        end else if (start_stop) begin
            state_q   <= (state_q == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
            running_q <= (state_q == ST_STOPPED);
        end
    end

    // A tick counts against the state before any coincident transition.
    assign count_en = tick_q && (state_q == ST_RUNNING);

    // Next count: BCD ripple with per-digit wrap; clear overrides a tick.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        count_d = count_q;
        roll_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            if (count_q.sec_o != 4'd9) begin
                count_d.sec_o = count_q.sec_o + 4'd1;
            end else begin
                count_d.sec_o = 4'd0;
                if (count_q.sec_t != 4'd5) begin
                    count_d.sec_t = count_q.sec_t + 4'd1;
                end else begin
                    count_d.sec_t = 4'd0;
                    if (count_q.min_o != 4'd9) begin
                        count_d.min_o = count_q.min_o + 4'd1;
                    end else begin
                        count_d.min_o = 4'd0;
                        if (count_q.min_t != 4'd5) begin
                            count_d.min_t = count_q.min_t + 4'd1;
                        end else begin
                            count_d.min_t = 4'd0;
                            roll_d        = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Count and rollover registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            roll_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            roll_q  <= roll_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic hold_q;

    // Lap toggles the display hold; clear always releases it.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
        end else if (clear) begin
            hold_q <= 1'b0;
        end else if (lap) begin
            hold_q <= ~hold_q;
        end
    end

    // The lap cycle itself still loads the display, which is what
    // captures the frozen value.
    assign hex_upd = ~hold_q;
`else
    assign hex_upd = 1'b1;
`endif

    // One decoder per digit; index 0 is sec_o.
    for (genvar i = 0; i < 4; i++) begin : g_dec
        seg7_decode u_dec (
            .bcd_i (count_q[i*4 +: 4]),
            .seg_o (seg_w[i])
        );
    end

    // Registered segment outputs, one cycle behind the count.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hex_q <= {4{SEG_ZERO}};
        end else if (hex_upd) begin
            hex_q <= seg_w;
        end
    end

    assign bcd      = count_q;
    assign hex0     = hex_q[0];
    assign hex1     = hex_q[1];
    assign hex2     = hex_q[2];
    assign hex3     = hex_q[3];
    assign running  = running_q;
    assign rollover = roll_q;

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Self-checking bench for stopwatch_mmss. The reference model keeps the
// elapsed time as a plain seconds count (0..3599) and derives BCD digits
// and segment codes from it arithmetically. Define STOPWATCH_LAP_EN to
// also exercise the lap hold.
module tb_stopwatch_mmss;

    localparam int SYNC_STAGES = 2;
    localparam int EDGE_MODE   = 0;
    localparam int SLOW_HALF   = 20;  // 40-cycle slow period
    localparam int FAST_HALF   = 4;   // used for long preloads

    logic        clk_in     = 1'b0;
    logic        rst_n      = 1'b0;
    logic        slow_clk   = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
    logic        lap        = 1'b0;
`endif
    logic [15:0] bcd;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic        running;
    logic        rollover;

    stopwatch_mmss #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .slow_clk   (slow_clk),
        .start_stop (start_stop),
        .clear      (clear),
`ifdef STOPWATCH_LAP_EN
        .lap        (lap),
`endif
        .bcd        (bcd),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .running    (running),
        .rollover   (rollover)
    );

    always #5 clk_in = ~clk_in;

    int checks    = 0;
    int errors    = 0;
    int exp_cnt   = 0;  // elapsed seconds
    bit exp_run   = 1'b0;
    bit exp_hold  = 1'b0;
    int held_cnt  = 0;
    int exp_rolls = 0;
    int roll_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m  = s / 60;
        int ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            default: return 7'h7f;
        endcase
    endfunction

    function automatic logic [27:0] hex_of(input int s);
        int m  = s / 60;
        int ss = s % 60;
        return {seg_of(m / 10), seg_of(m % 10), seg_of(ss / 10), seg_of(ss % 10)};
    endfunction

    function automatic logic [27:0] hex_now();
        return {hex3, hex2, hex1, hex0};
    endfunction

    // One counted tick in the model.
    function automatic void model_tick();
        if (exp_run) begin
            if (exp_cnt == 3599) begin
                exp_cnt = 0;
                exp_rolls++;
            end else begin
                exp_cnt++;
            end
        end
    endfunction

    always @(negedge clk_in) if (rollover === 1'b1) roll_seen++;

    task automatic slow_cycle(input int half);
        @(posedge clk_in);
        #1 slow_clk = 1'b1;
        model_tick();
        repeat (half) @(posedge clk_in);
        #1 slow_clk = 1'b0;
        if (EDGE_MODE != 0) model_tick();
        repeat (half) @(posedge clk_in);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk_in);
    endtask

    task automatic pulse_ss();
        @(posedge clk_in);
        #1 start_stop = 1'b1;
        @(posedge clk_in);
        #1 start_stop = 1'b0;
        exp_run = !exp_run;
        settle();
    endtask

    task automatic pulse_clr();
        @(posedge clk_in);
        #1 clear = 1'b1;
        @(posedge clk_in);
        #1 clear = 1'b0;
        exp_cnt  = 0;
        exp_hold = 1'b0;
        settle();
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic pulse_lap();
        @(posedge clk_in);
        #1 lap = 1'b1;
        @(posedge clk_in);
        #1 lap = 1'b0;
        if (!exp_hold) begin
            exp_hold = 1'b1;
            held_cnt = exp_cnt;
        end else begin
            exp_hold = 1'b0;
        end
        settle();
    endtask
`endif

    task automatic check_all(input string tag);
        @(negedge clk_in);
        check({tag, ".bcd"}, 32'(bcd), 32'(to_bcd(exp_cnt)));
        check({tag, ".run"}, 32'(running), 32'(exp_run));
        check({tag, ".hex"}, 32'(hex_now()), 32'(hex_of(exp_hold ? held_cnt : exp_cnt)));
    endtask

    // Rise on slow_clk, then drive ctrl input high so it lands on the same
    // edge at which the registered tick is consumed (rise + SYNC_STAGES + 2).
    task automatic rise_with(input bit do_ss, input bit do_clr);
        @(posedge clk_in);
        #1 slow_clk = 1'b1;
        repeat (SYNC_STAGES + 1) @(posedge clk_in);
        #1;
        start_stop = do_ss;
        clear      = do_clr;
        @(posedge clk_in);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        repeat (SLOW_HALF) @(posedge clk_in);
        #1 slow_clk = 1'b0;
        repeat (SLOW_HALF) @(posedge clk_in);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int op;

        // Reset state.
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst.bcd", 32'(bcd), 32'h0);
        check("rst.hex", 32'(hex_now()), 32'(hex_of(0)));
        check("rst.run", 32'(running), 32'h0);
        check("rst.roll", 32'(rollover), 32'h0);
        rst_n = 1'b1;

        // Slow edges while stopped change nothing.
        repeat (3) slow_cycle(SLOW_HALF);
        check_all("idle");

        // Start and count twelve rises; last rise checks tick latency.
        pulse_ss();
        check_all("start");
        repeat (11) slow_cycle(SLOW_HALF);
        @(posedge clk_in);
        #1 slow_clk = 1'b1;
        repeat (SYNC_STAGES + 1) @(posedge clk_in);
        @(negedge clk_in);
        check("lat.before", 32'(bcd), 32'h0011);
        @(posedge clk_in);
        @(negedge clk_in);
        model_tick();
        check("lat.after", 32'(bcd), 32'h0012);
        repeat (SLOW_HALF) @(posedge clk_in);
        #1 slow_clk = 1'b0;
        repeat (SLOW_HALF) @(posedge clk_in);
        check_all("twelve");

        // Tick coincident with stop still counts, then ticks are dropped.
        rise_with(1'b1, 1'b0);
        model_tick();
        exp_run = 1'b0;
        check_all("ss_tick");
        slow_cycle(SLOW_HALF);
        check_all("drop");
        pulse_ss();

        // Clear coincident with a tick at 00:09.
        pulse_clr();
        repeat (9) slow_cycle(SLOW_HALF);
        check_all("nine");
        r0 = roll_seen;
        rise_with(1'b0, 1'b1);
        exp_cnt = 0;
        check_all("clr_tick");
        check("clr_tick.roll", 32'(roll_seen - r0), 32'h0);

        // Preload to 59:59 and wrap.
        pulse_clr();
        for (int i = 0; i < 4000 && exp_cnt != 3599; i++) slow_cycle(FAST_HALF);
        check("pre.bcd", 32'(bcd), 32'h5959);
        r0 = roll_seen;
        slow_cycle(FAST_HALF);
        check_all("wrap");
        check("wrap.bcd", 32'(bcd), 32'h0000);
        check("wrap.roll", 32'(roll_seen - r0), 32'h1);

`ifdef STOPWATCH_LAP_EN
        // Lap hold freezes the display while counting continues.
        pulse_clr();
        if (!exp_run) pulse_ss();
        repeat (5) slow_cycle(SLOW_HALF);
        pulse_lap();
        repeat (4) slow_cycle(SLOW_HALF);
        check_all("lap_hold");
        check("lap_hold.hex", 32'(hex_now()), 32'(hex_of(5)));
        check("lap_hold.bcd", 32'(bcd), 32'h0009);
        pulse_lap();
        check("lap_rel.hex", 32'(hex_now()), 32'(hex_of(9)));
`endif

        // Randomised mix of controls and ticks.
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 11));
            if (op == 0) begin
                pulse_ss();
            end else if (op == 1) begin
                pulse_clr();
`ifdef STOPWATCH_LAP_EN
            end else if (op == 2) begin
                pulse_lap();
`endif
            end else begin
                slow_cycle(int'($urandom_range(5, 20)));
            end
            check_all("rand");
        end
        check("rolls.total", 32'(roll_seen), 32'(exp_rolls));

        // Asynchronous reset in the middle of counting at 12:34.
        pulse_clr();
        if (!exp_run) pulse_ss();
        for (int i = 0; i < 1000 && exp_cnt != 754; i++) slow_cycle(FAST_HALF);
        check_all("pre_rst");
        check("pre_rst.bcd", 32'(bcd), 32'h1234);
        @(posedge clk_in);
        #3 rst_n = 1'b0;
        #1;
        check("arst.bcd", 32'(bcd), 32'h0);
        check("arst.hex", 32'(hex_now()), 32'(hex_of(0)));
        check("arst.run", 32'(running), 32'h0);
        check("arst.roll", 32'(rollover), 32'h0);
        exp_cnt  = 0;
        exp_run  = 1'b0;
        exp_hold = 1'b0;
        #20 rst_n = 1'b1;
        settle();
        check_all("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
